// File: rtl/mod_exp_pkg.sv
// Shared types for the 64-bit square-and-multiply exponentiation sequencer.
package mod_exp_pkg;
  localparam int WIDTH_DEF   = 64;
  localparam int E_WIDTH_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_NEXT, S_FIN
  } state_t;

  typedef enum logic {OP_SQR, OP_MULX} op_t;
endpackage

// File: rtl/mod_exp64_ctrl.sv
// Left-to-right square-and-multiply controller driving an external modular
// multiplier through a start/done job port.
module mod_exp64_ctrl
  import mod_exp_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int E_WIDTH = E_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   base,
  input  logic [E_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]   mod_n,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               err,
  output logic               mm_start,
  output logic [WIDTH-1:0]   mm_a,
  output logic [WIDTH-1:0]   mm_b,
  output logic [WIDTH-1:0]   mm_n,
  input  logic [WIDTH-1:0]   mm_p,
  input  logic               mm_done
);
  localparam int IW = $clog2(E_WIDTH);

  state_t             state, state_nxt;
  op_t                op_q, job_op;
  logic [WIDTH-1:0]   x_q, n_q, r_q, job_a, job_b;
  logic [E_WIDTH-1:0] e_q;
  logic [IW-1:0]      idx_q;
  logic               accept, job_ld, idx_dec, res_ld;

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FIN);
  assign mm_start = (state == S_ISSUE);

  // Operands are loaded on entry to ISSUE so they are already stable in the
  // mm_start cycle. The first job from SCAN is always 1*X.
  assign job_a = (state == S_SCAN) ? WIDTH'(1) : r_q;
  assign job_b = (job_op == OP_MULX) ? x_q : r_q;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    job_ld    = 1'b0;
    job_op    = op_q;
    idx_dec   = 1'b0;
    res_ld    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        accept = 1'b1;
        if (mod_n == '0 || exp == '0) state_nxt = S_FIN;
        else                          state_nxt = S_SCAN;
      end
      S_SCAN: begin
        if (e_q[idx_q]) begin
          job_ld    = 1'b1;
          job_op    = OP_MULX;
          state_nxt = S_ISSUE;
        end else begin
          idx_dec = 1'b1;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (mm_done) state_nxt = S_NEXT;
      S_NEXT: begin
        if (op_q == OP_SQR && e_q[idx_q]) begin
          job_ld    = 1'b1;
          job_op    = OP_MULX;
          state_nxt = S_ISSUE;
        end else if (idx_q == '0) begin
          res_ld    = 1'b1;
          state_nxt = S_FIN;
        end else begin
          idx_dec   = 1'b1;
          job_ld    = 1'b1;
          job_op    = OP_SQR;
          state_nxt = S_ISSUE;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= OP_SQR;
      x_q    <= '0;
      e_q    <= '0;
      n_q    <= '0;
      r_q    <= '0;
      idx_q  <= '0;
      result <= '0;
      err    <= 1'b0;
      mm_a   <= '0;
      mm_b   <= '0;
      mm_n   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_q    <= base;
        e_q    <= exp;
        n_q    <= mod_n;
        idx_q  <= IW'(E_WIDTH - 1);
        err    <= (mod_n == '0);
        // Only the E==0 fast path with N>1 yields a nonzero immediate result.
        result <= (mod_n != '0 && exp == '0 && mod_n != WIDTH'(1)) ? WIDTH'(1) : '0;
      end
      if (idx_dec) idx_q <= idx_q - 1'b1;
      if (job_ld) begin
        op_q <= job_op;
        mm_a <= job_a;
        mm_b <= job_b;
        mm_n <= n_q;
        if (state == S_SCAN) r_q <= WIDTH'(1);
      end
      if (state == S_WAIT && mm_done) r_q <= mm_p;
      if (res_ld) result <= r_q;
    end
  end
endmodule

// File: tb/tb_mod_exp64_ctrl.sv
// Bench for mod_exp64_ctrl with a behavioural modular multiplier of
// configurable latency and a result/err scoreboard.
module tb_mod_exp64_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [63:0] base, e_in, mod_n;
  logic        busy, done, err, mm_start, mm_done;
  logic [63:0] result, mm_a, mm_b, mm_n, mm_p;

  int n_tests = 0;
  int n_fail  = 0;
  int jobs    = 0;
  int lat_fix = 3;
  bit lat_rnd = 0;
  bit model_busy = 0;
  logic [63:0] exp_n;
  logic [63:0] sb_res[$];
  logic        sb_err[$];

  mod_exp64_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exp(e_in),
    .mod_n(mod_n), .busy(busy), .done(done), .result(result), .err(err),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_p(mm_p), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  // Right-to-left binary exponentiation with 128-bit intermediates.
  function automatic logic [63:0] ref_modexp(input logic [63:0] x, e, n);
    logic [127:0] r, b;
    if (n == 0) return 64'd0;
    r = 128'd1 % n;
    b = x % n;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r[63:0];
  endfunction

  function automatic int ref_jobs(input logic [63:0] e, n);
    int l = 0, p = 0;
    if (e == 0 || n == 0) return 0;
    for (int i = 0; i < 64; i++) if (e[i]) begin l = i + 1; p++; end
    return l + p - 1;
  endfunction

  // Multiplier model: job seen in the ISSUE cycle, done in the M-th WAIT cycle.
  initial begin
    logic [127:0] p;
    int m;
    mm_done = 1'b0;
    mm_p    = '0;
    forever begin
      @(negedge clk);
      if (mm_start === 1'b1) begin
        model_busy = 1;
        jobs++;
        n_tests++;
        if (mm_n !== exp_n) begin
          n_fail++;
          $display("FAIL mm_n: got %h want %h", mm_n, exp_n);
        end
        p = ({64'd0, mm_a} * {64'd0, mm_b}) % {64'd0, mm_n};
        m = lat_rnd ? int'($urandom_range(80, 1)) : lat_fix;
        @(posedge clk);
        repeat (m - 1) @(posedge clk);
        #1 mm_done = 1'b1; mm_p = p[63:0];
        @(posedge clk);
        #1 mm_done = 1'b0;
        model_busy = 0;
      end
    end
  end

  task automatic start_run(input logic [63:0] x, e, n);
    @(negedge clk);
    base = x; e_in = e; mod_n = n; start = 1'b1;
    exp_n = n; jobs = 0;
    sb_res.push_back(ref_modexp(x, e, n));
    sb_err.push_back(n == 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc counts negedges since the accept edge; latency = cyc + 1.
  task automatic wait_done(output int cyc, output bit ok);
    cyc = 1; ok = 0;
    for (int i = 0; i < 20000; i++) begin
      if (done === 1'b1) begin ok = 1; return; end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0)   begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_tests++; if (result !== 64'd0) begin n_fail++; $display("FAIL rst_result: got %h want 0", result); end
    n_tests++; if (err !== 1'b0)    begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_tests++; if (mm_start !== 1'b0) begin n_fail++; $display("FAIL rst_mm_start: got %b want 0", mm_start); end
    n_tests++; if ({mm_a, mm_b, mm_n} !== '0) begin n_fail++; $display("FAIL rst_mm_ops: got %h %h %h want 0", mm_a, mm_b, mm_n); end
  endtask

  task automatic test_run(input string name, input logic [63:0] x, e, n, input int want_lat);
    int cyc; bit ok; logic [63:0] r_exp; logic e_exp;
    start_run(x, e, n);
    wait_done(cyc, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL %s_timeout: no done within budget", name);
      sb_res.delete(); sb_err.delete();
      return;
    end
    r_exp = sb_res.pop_front(); e_exp = sb_err.pop_front();
    if (result !== r_exp) begin n_fail++; $display("FAIL %s_result: got %h want %h", name, result, r_exp); end
    n_tests++; if (err !== e_exp) begin n_fail++; $display("FAIL %s_err: got %b want %b", name, err, e_exp); end
    n_tests++; if (jobs != ref_jobs(e, n)) begin n_fail++; $display("FAIL %s_jobs: got %0d want %0d", name, jobs, ref_jobs(e, n)); end
    if (want_lat > 0) begin
      n_tests++;
      if (cyc + 1 != want_lat) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, cyc + 1, want_lat); end
    end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL %s_after: busy %b done %b want 0 0", name, busy, done); end
  endtask

  task automatic test_busy_start();
    int cyc = 0, ndone = 0; logic [63:0] r_exp;
    start_run(64'd3, 64'd13, 64'd101);
    base = 64'd7; e_in = 64'd99; mod_n = 64'd555; start = 1'b1;
    while (cyc < 20000 && done !== 1'b1) begin @(negedge clk); cyc++; end
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL busy_start_timeout: no done"); start = 1'b0; return; end
    ndone++;
    r_exp = sb_res.pop_front(); void'(sb_err.pop_front());
    if (result !== r_exp) begin n_fail++; $display("FAIL busy_start_result: got %h want %h", result, r_exp); end
    start = 1'b0;
    repeat (6) begin @(negedge clk); if (done === 1'b1) ndone++; end
    n_tests++; if (ndone != 1) begin n_fail++; $display("FAIL busy_start_dones: got %0d want 1", ndone); end
    n_tests++; if (result !== r_exp) begin n_fail++; $display("FAIL busy_start_held: got %h want %h", result, r_exp); end
  endtask

  task automatic test_reset_mid();
    int bad = 0, w = 0;
    lat_fix = 20;
    start_run(64'd2, 64'd10, 64'd1000);
    while (jobs < 1 && w < 200) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb_res.delete(); sb_err.delete();
    @(negedge clk);
    rst_n = 1'b1;
    w = 0;
    while ((model_busy || w < 2) && w < 100) begin
      @(negedge clk); w++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0 || err !== 1'b0 || mm_start !== 1'b0) bad++;
    end
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0 || mm_start !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL reset_mid_stale: %0d bad cycles want 0", bad); end
    n_tests++; if (model_busy) begin n_fail++; $display("FAIL reset_mid_model: stale job still pending want delivered"); end
    lat_fix = 3;
    test_run("after_reset", 64'd2, 64'd10, 64'd1000, 88);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base = '0; e_in = '0; mod_n = '0; exp_n = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    lat_fix = 3;
    test_run("basic", 64'd2, 64'd10, 64'd1000, 88);
    test_run("e0_n7", 64'd9, 64'd0, 64'd7, 2);
    test_run("e0_n1", 64'd9, 64'd0, 64'd1, 2);
    test_run("n0", 64'd123, 64'd5, 64'd0, 2);
    test_run("n1", 64'd77, 64'd6, 64'd1, 0);
    test_run("wide", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1234_5678, 0);
    n_tests++;
    if (ref_modexp(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1234_5678) !== 64'h147c1e9) begin
      n_fail++; $display("FAIL wide_ref: got %h want 147c1e9", ref_modexp(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1234_5678));
    end
    lat_fix = 2;
    test_run("fermat", 64'd5, 64'hFFFF_FFFF_FFFF_FFC4, 64'hFFFF_FFFF_FFFF_FFC5, 0);
    lat_rnd = 1;
    test_run("fermat_rnd", 64'd5, 64'hFFFF_FFFF_FFFF_FFC4, 64'hFFFF_FFFF_FFFF_FFC5, 0);
    test_run("rnd_small", 64'd1234567, 64'd65537, 64'd1000003, 0);
    lat_rnd = 0;
    lat_fix = 3;
    test_busy_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
